// File: rtl/lsu_port.sv
// Load/store unit for the data port (port B) of the shared instruction/data RAM.
// One RV32I load/store at a time: address/lane setup, RAM access, load extraction, response pulse.
module lsu_port #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_ena,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t                state;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [1:0]            lane_q;

  logic                  req_err;
  logic [3:0]            st_we;
  logic [DATA_WIDTH-1:0] st_din;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ld_data;

  assign req_ready = (state == IDLE);

  always_comb begin
    req_err = 1'b0;
    if (!(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) req_err = 1'b1;
    if (req_we && req_funct3[2])                                        req_err = 1'b1;
    if (req_funct3[1:0] == 2'b01 && req_addr[0])                        req_err = 1'b1;
    if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)                 req_err = 1'b1;
    if (|req_addr[31:ADDR_WIDTH+2])                                     req_err = 1'b1;
  end

  // Store data is replicated across lanes so the byte enables alone select the target bytes.
  always_comb begin
    st_we  = 4'b0000;
    st_din = '0;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          st_we  = 4'b0001 << req_addr[1:0];
          st_din = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          st_we  = 4'b0011 << req_addr[1:0];
          st_din = {2{req_wdata[15:0]}};
        end
        default: begin
          st_we  = 4'b1111;
          st_din = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    shifted = mem_dout >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_data = {24'd0, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      lane_q     <= 2'b00;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_ena    <= 1'b0;
      mem_we     <= 4'b0000;
      mem_addr   <= '0;
      mem_din    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            lane_q   <= req_addr[1:0];
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state    <= ACCESS;
              mem_ena  <= 1'b1;
              mem_we   <= st_we;
              mem_addr <= req_addr[ADDR_WIDTH+1:2];
              mem_din  <= st_din;
            end
          end
        end
        ACCESS: begin
          mem_ena <= 1'b0;
          mem_we  <= 4'b0000;
          if (we_q) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= ld_data;
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_port.sv
// Directed self-checking bench for lsu_port with a behavioural byte-enabled RAM on port B.
module tb_lsu_port;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [31:0]   req_addr = 32'd0;
  logic [31:0]   req_wdata = 32'd0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_ena;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;

  logic [31:0]   ram [0:(1<<AW)-1];

  int tests = 0;
  int fails = 0;

  // Values observed by do_req
  logic          e_ena;
  logic [3:0]    e_we;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_din;
  int            r_lat, r_cnt, ena_cnt;
  logic          r_err;
  logic [31:0]   r_rdata;

  lsu_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_ena(mem_ena), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_ena) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) ram[mem_addr][8*i +: 8] <= mem_din[8*i +: 8];
      mem_dout <= ram[mem_addr];
    end
  end

  // Issues one request from posedge+1 phase and observes five sample points after the accept edge.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    tests++;
    if (!req_ready) begin
      fails++;
      $display("FAIL ready_timeout got req_ready=%b exp 1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    e_ena = mem_ena; e_we = mem_we; e_addr = mem_addr; e_din = mem_din;
    ena_cnt = int'(mem_ena);
    r_lat = 0; r_cnt = 0; r_err = 1'b0; r_rdata = 32'hx;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
        ena_cnt += int'(mem_ena);
      end
      if (resp_valid) begin
        r_cnt++;
        if (r_lat == 0) begin
          r_lat = k; r_err = resp_err; r_rdata = resp_rdata;
        end
      end
    end
  endtask

  task automatic test_reset;
    tests++;
    if ({req_ready, resp_valid, resp_err, mem_ena} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_ctl got rdy/vld/err/ena=%b exp 1000", {req_ready, resp_valid, resp_err, mem_ena});
    end
    tests++;
    if ({mem_we, mem_addr, mem_din, resp_rdata} !== '0) begin
      fails++;
      $display("FAIL reset_data got we=%h addr=%h din=%h rdata=%h exp all 0", mem_we, mem_addr, mem_din, resp_rdata);
    end
  endtask

  task automatic test_sw;
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    tests++;
    if ({e_ena, e_we, e_addr, e_din} !== {1'b1, 4'b1111, 10'd4, 32'hDEADBEEF}) begin
      fails++;
      $display("FAIL sw_port got ena=%b we=%b addr=%0d din=%h exp 1 1111 4 deadbeef", e_ena, e_we, e_addr, e_din);
    end
    tests++;
    if (r_lat !== 2 || r_cnt !== 1 || r_err !== 1'b0 || r_rdata !== 32'd0 || ena_cnt !== 1) begin
      fails++;
      $display("FAIL sw_resp got lat=%0d cnt=%0d err=%b rdata=%h ena_cycles=%0d exp 2 1 0 0 1", r_lat, r_cnt, r_err, r_rdata, ena_cnt);
    end
    tests++;
    if (ram[4] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL sw_ram got %h exp deadbeef", ram[4]);
    end
  endtask

  task automatic test_byte;
    do_req(1'b1, 3'b000, 32'h13, 32'h000000A5);
    tests++;
    if ({e_we, e_addr, e_din} !== {4'b1000, 10'd4, 32'hA5A5A5A5} || r_lat !== 2) begin
      fails++;
      $display("FAIL sb_port got we=%b addr=%0d din=%h lat=%0d exp 1000 4 a5a5a5a5 2", e_we, e_addr, e_din, r_lat);
    end
    do_req(1'b0, 3'b000, 32'h13, 32'h0);
    tests++;
    if (e_we !== 4'b0000 || r_lat !== 3 || r_err !== 1'b0 || r_rdata !== 32'hFFFFFFA5) begin
      fails++;
      $display("FAIL lb got we=%b lat=%0d err=%b rdata=%h exp 0000 3 0 ffffffa5", e_we, r_lat, r_err, r_rdata);
    end
    do_req(1'b0, 3'b100, 32'h13, 32'h0);
    tests++;
    if (r_lat !== 3 || r_rdata !== 32'h000000A5) begin
      fails++;
      $display("FAIL lbu got lat=%0d rdata=%h exp 3 000000a5", r_lat, r_rdata);
    end
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    tests++;
    if (r_lat !== 3 || r_rdata !== 32'hA5ADBEEF) begin
      fails++;
      $display("FAIL lw_merged got lat=%0d rdata=%h exp 3 a5adbeef", r_lat, r_rdata);
    end
    do_req(1'b0, 3'b000, 32'h11, 32'h0);
    tests++;
    if (r_rdata !== 32'hFFFFFFBE) begin
      fails++;
      $display("FAIL lb_lane1 got rdata=%h exp ffffffbe", r_rdata);
    end
  endtask

  task automatic test_half;
    do_req(1'b1, 3'b001, 32'h22, 32'h00008001);
    tests++;
    if ({e_we, e_addr, e_din} !== {4'b1100, 10'd8, 32'h80018001}) begin
      fails++;
      $display("FAIL sh_port got we=%b addr=%0d din=%h exp 1100 8 80018001", e_we, e_addr, e_din);
    end
    do_req(1'b0, 3'b001, 32'h22, 32'h0);
    tests++;
    if (r_lat !== 3 || r_rdata !== 32'hFFFF8001) begin
      fails++;
      $display("FAIL lh got lat=%0d rdata=%h exp 3 ffff8001", r_lat, r_rdata);
    end
    do_req(1'b0, 3'b101, 32'h22, 32'h0);
    tests++;
    if (r_lat !== 3 || r_rdata !== 32'h00008001) begin
      fails++;
      $display("FAIL lhu got lat=%0d rdata=%h exp 3 00008001", r_lat, r_rdata);
    end
  endtask

  task automatic test_errors;
    logic [31:0] vec_addr [5];
    logic [2:0]  vec_f3   [5];
    logic        vec_we   [5];
    vec_we[0] = 1'b0; vec_f3[0] = 3'b010; vec_addr[0] = 32'h06;
    vec_we[1] = 1'b1; vec_f3[1] = 3'b001; vec_addr[1] = 32'h01;
    vec_we[2] = 1'b0; vec_f3[2] = 3'b011; vec_addr[2] = 32'h00;
    vec_we[3] = 1'b1; vec_f3[3] = 3'b000; vec_addr[3] = 32'h1 << (AW + 2);
    vec_we[4] = 1'b1; vec_f3[4] = 3'b100; vec_addr[4] = 32'h00;
    for (int i = 0; i < 5; i++) begin
      do_req(vec_we[i], vec_f3[i], vec_addr[i], 32'hFFFFFFFF);
      tests++;
      if (r_lat !== 1 || r_cnt !== 1 || r_err !== 1'b1 || r_rdata !== 32'd0 || ena_cnt !== 0) begin
        fails++;
        $display("FAIL err_%0d got lat=%0d cnt=%0d err=%b rdata=%h ena_cycles=%0d exp 1 1 1 0 0", i, r_lat, r_cnt, r_err, r_rdata, ena_cnt);
      end
    end
    tests++;
    if (ram[0] !== 32'h11223344) begin
      fails++;
      $display("FAIL err_ram got %h exp 11223344", ram[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] rdy;
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0;
    @(posedge clk); #1;
    req_addr = 32'h4;
    rdy[0] = req_ready;
    @(posedge clk); #1; rdy[1] = req_ready;
    @(posedge clk); #1; rdy[2] = req_ready;
    tests++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h11223344) begin
      fails++;
      $display("FAIL b2b_first got vld=%b rdata=%h exp 1 11223344", resp_valid, resp_rdata);
    end
    @(posedge clk); #1; rdy[3] = req_ready;
    tests++;
    if (rdy !== 4'b1000 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_ready got ready(idle,resp,cap,acc)=%b vld=%b exp 1000 0", rdy, resp_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests++;
    if (mem_ena !== 1'b1 || mem_addr !== 10'd1 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_accept got ena=%b addr=%0d rdy=%b exp 1 1 0", mem_ena, mem_addr, req_ready);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h55667788) begin
      fails++;
      $display("FAIL b2b_second got vld=%b rdata=%h exp 1 55667788", resp_valid, resp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests++;
    if (mem_ena !== 1'b1 || mem_we !== 4'b1111) begin
      fails++;
      $display("FAIL rst_pre got ena=%b we=%b exp 1 1111", mem_ena, mem_we);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (mem_ena !== 1'b0 || mem_we !== 4'b0000 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_async got ena=%b we=%b vld=%b exp 0 0000 0", mem_ena, mem_we, resp_valid);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_ready got %b exp 1", req_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    tests++;
    if (ram[16] !== 32'hCAFEF00D || seen !== 0) begin
      fails++;
      $display("FAIL rst_no_write got ram=%h resp_cycles=%0d exp cafef00d 0", ram[16], seen);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'd0;
    ram[0]  = 32'h11223344;
    ram[1]  = 32'h55667788;
    ram[16] = 32'hCAFEF00D;
    mem_dout = 32'd0;
    #12;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_sw();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
